// File: rtl/dds_ctrl_mc.sv
// Multi-channel DDS control: channel-addressed config registers, one shared
// restoring divider for unit conversion, and a 3-stage gain/offset/saturate datapath.
module dds_ctrl_mc #(
  parameter int CH_NUM   = 2,
  parameter int FRQ_W    = 16,
  parameter int FWORD_W  = 27,
  parameter int FRQ_DEN  = 1000000,
  parameter int PWORD_W  = 8,
  parameter int DATA_W   = 14,
  parameter int AMP_FULL = 3000,
  parameter int OFS_FULL = 6000,
  localparam int CH_W    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [CH_W-1:0]             i_cfg_ch,
  input  logic [2:0]                  i_cfg_sel,
  input  logic [15:0]                 i_cfg_data,
  input  logic                        i_cfg_vld,
  output logic                        o_cfg_rdy,
  output logic                        o_cfg_drop,
  output logic [CH_NUM-1:0]           o_run,
  output logic [CH_NUM*3-1:0]         o_mode,
  output logic [CH_NUM-1:0]           o_mode_vld,
  output logic [CH_NUM*FWORD_W-1:0]   o_fword,
  output logic [CH_NUM-1:0]           o_fword_vld,
  output logic [CH_NUM*PWORD_W-1:0]   o_pword,
  output logic [CH_NUM-1:0]           o_pword_vld,
  output logic [CH_NUM*10-1:0]        o_duty,
  output logic [CH_NUM-1:0]           o_duty_vld,
  input  logic [CH_NUM*DATA_W-1:0]    i_dds_data,
  input  logic                        i_dds_data_vld,
  output logic [CH_NUM*DATA_W-1:0]    o_pay_dds_data,
  output logic                        o_pay_vld
);

  localparam int NUM_W  = FRQ_W + FWORD_W;
  localparam int DEN_W  = 32;
  localparam int CNT_W  = $clog2(NUM_W);
  localparam int GAIN_W = 17;
  localparam int P_W    = DATA_W + GAIN_W;
  localparam int S_W    = DATA_W + 2;
  localparam logic [DATA_W-1:0] DMAX = '1;

  localparam logic [2:0] SEL_RUN   = 3'd0;
  localparam logic [2:0] SEL_TYPE  = 3'd1;
  localparam logic [2:0] SEL_FRQ   = 3'd2;
  localparam logic [2:0] SEL_AMP   = 3'd3;
  localparam logic [2:0] SEL_P2P   = 3'd4;
  localparam logic [2:0] SEL_OFS   = 3'd5;
  localparam logic [2:0] SEL_PHASE = 3'd6;
  localparam logic [2:0] SEL_DUTY  = 3'd7;

  typedef enum logic [1:0] {IDLE, LOAD, DIV, WB} state_e;

  state_e                             state_q;
  logic                               rdy_q, drop_q;
  logic [CH_NUM-1:0]                  run_q, mode_vld_q, fword_vld_q, pword_vld_q, duty_vld_q;
  logic [CH_NUM-1:0][2:0]             mode_q;
  logic [CH_NUM-1:0][FWORD_W-1:0]     fword_q;
  logic [CH_NUM-1:0][PWORD_W-1:0]     pword_q;
  logic [CH_NUM-1:0][9:0]             duty_q;
  logic [CH_NUM-1:0][GAIN_W-1:0]      gain_q;
  logic [CH_NUM-1:0][DATA_W-1:0]      ofs_q;
  logic [2:0]                         sel_q;
  logic [CH_W-1:0]                    ch_q;
  logic [15:0]                        data_q;
  logic [NUM_W-1:0]                   num_q;
  logic [DEN_W-1:0]                   den_q, rem_q;
  logic [CNT_W-1:0]                   cnt_q;

  logic                               cfg_ok;
  logic [15:0]                        amp_raw, amp_c, ph_c, ofs_c;
  logic [NUM_W-1:0]                   ld_num;
  logic [DEN_W-1:0]                   ld_den;
  logic [DEN_W:0]                     rem_sh;
  logic                               ge;

  assign cfg_ok = i_cfg_vld & rdy_q & ({1'b0, i_cfg_ch} < (CH_W+1)'(CH_NUM));

  // Divider operands are built from the latched write so the config port is free during LOAD.
  always_comb begin
    amp_raw = (sel_q == SEL_P2P) ? {4'b0, data_q[12:1]} : data_q;
    amp_c   = (amp_raw > 16'd4095) ? 16'd4095 : amp_raw;
    ph_c    = (data_q > 16'd3599) ? 16'd3599 : data_q;
    ofs_c   = (data_q > 16'(OFS_FULL)) ? 16'(OFS_FULL) : data_q;
    ld_num  = '0;
    ld_den  = '0;
    case (sel_q)
      SEL_FRQ: begin
        ld_num = NUM_W'(data_q[FRQ_W-1:0]) << FWORD_W;
        ld_den = DEN_W'(FRQ_DEN);
      end
      SEL_PHASE: begin
        ld_num = NUM_W'(ph_c) << PWORD_W;
        ld_den = DEN_W'(3600);
      end
      SEL_AMP, SEL_P2P: begin
        ld_num = NUM_W'(amp_c) << 16;
        ld_den = DEN_W'(AMP_FULL);
      end
      SEL_OFS: begin
        ld_num = NUM_W'(ofs_c) << DATA_W;
        ld_den = DEN_W'(OFS_FULL);
      end
      default: ;
    endcase
  end

  assign rem_sh = {rem_q, num_q[NUM_W-1]};
  assign ge     = rem_sh >= {1'b0, den_q};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b1;
      drop_q      <= 1'b0;
      run_q       <= '1;
      mode_q      <= '0;
      mode_vld_q  <= '0;
      fword_vld_q <= '0;
      pword_vld_q <= '0;
      duty_vld_q  <= '0;
      pword_q     <= '0;
      ofs_q       <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        fword_q[c] <= FWORD_W'(64);
        duty_q[c]  <= 10'd1;
        gain_q[c]  <= GAIN_W'(65536);
      end
      sel_q  <= '0;
      ch_q   <= '0;
      data_q <= '0;
      num_q  <= '0;
      den_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else begin
      mode_vld_q  <= '0;
      fword_vld_q <= '0;
      pword_vld_q <= '0;
      duty_vld_q  <= '0;
      drop_q      <= i_cfg_vld & ~cfg_ok;
      case (state_q)
        IDLE: if (cfg_ok) begin
          case (i_cfg_sel)
            SEL_RUN:  run_q[i_cfg_ch] <= i_cfg_data[0];
            SEL_TYPE: begin
              mode_q[i_cfg_ch]     <= i_cfg_data[2:0];
              mode_vld_q[i_cfg_ch] <= 1'b1;
            end
            SEL_DUTY: begin
              duty_q[i_cfg_ch]     <= i_cfg_data[9:0];
              duty_vld_q[i_cfg_ch] <= 1'b1;
            end
            default: begin
              sel_q   <= i_cfg_sel;
              ch_q    <= i_cfg_ch;
              data_q  <= i_cfg_data;
              rdy_q   <= 1'b0;
              state_q <= LOAD;
            end
          endcase
        end
        LOAD: begin
          num_q   <= ld_num;
          den_q   <= ld_den;
          rem_q   <= '0;
          cnt_q   <= '0;
          state_q <= DIV;
        end
        DIV: begin
          num_q <= {num_q[NUM_W-2:0], ge};
          rem_q <= ge ? (rem_sh[DEN_W-1:0] - den_q) : rem_sh[DEN_W-1:0];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(NUM_W-1)) state_q <= WB;
        end
        WB: begin
          // num_q now holds the truncated quotient
          case (sel_q)
            SEL_FRQ: begin
              fword_q[ch_q]     <= num_q[FWORD_W-1:0];
              fword_vld_q[ch_q] <= 1'b1;
            end
            SEL_PHASE: begin
              pword_q[ch_q]     <= num_q[PWORD_W-1:0];
              pword_vld_q[ch_q] <= 1'b1;
            end
            SEL_AMP, SEL_P2P: gain_q[ch_q] <= num_q[GAIN_W-1:0];
            SEL_OFS: ofs_q[ch_q] <= (num_q > NUM_W'(DMAX)) ? DMAX : num_q[DATA_W-1:0];
            default: ;
          endcase
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [CH_NUM-1:0][P_W-1:0]    p_q;
  logic [CH_NUM-1:0][S_W-1:0]    s_q;
  logic [CH_NUM-1:0][DATA_W-1:0] out_q;
  logic [2:0]                    vld_sr_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_q      <= '0;
      s_q      <= '0;
      out_q    <= '0;
      vld_sr_q <= '0;
    end else begin
      vld_sr_q <= {vld_sr_q[1:0], i_dds_data_vld};
      for (int c = 0; c < CH_NUM; c++) begin
        p_q[c]   <= P_W'(i_dds_data[c*DATA_W +: DATA_W]) * P_W'(gain_q[c]);
        s_q[c]   <= S_W'(p_q[c] >> 16) + S_W'(ofs_q[c]);
        out_q[c] <= (s_q[c] > S_W'(DMAX)) ? DMAX : s_q[c][DATA_W-1:0];
      end
    end
  end

  assign o_cfg_rdy      = rdy_q;
  assign o_cfg_drop     = drop_q;
  assign o_run          = run_q;
  assign o_mode         = mode_q;
  assign o_mode_vld     = mode_vld_q;
  assign o_fword        = fword_q;
  assign o_fword_vld    = fword_vld_q;
  assign o_pword        = pword_q;
  assign o_pword_vld    = pword_vld_q;
  assign o_duty         = duty_q;
  assign o_duty_vld     = duty_vld_q;
  assign o_pay_dds_data = out_q;
  assign o_pay_vld      = vld_sr_q[2];

endmodule

// File: tb/tb_dds_ctrl_mc.sv
// Directed bench for dds_ctrl_mc with three channels so an out-of-range channel index is reachable.
module tb_dds_ctrl_mc;
  localparam int CH_NUM  = 3;
  localparam int CH_W    = 2;
  localparam int FWORD_W = 27;
  localparam int PWORD_W = 8;
  localparam int DATA_W  = 14;
  localparam int NUM_W   = 43;

  logic                       clk = 1'b0;
  logic                       rst_n = 1'b0;
  logic [CH_W-1:0]            cfg_ch = '0;
  logic [2:0]                 cfg_sel = '0;
  logic [15:0]                cfg_data = '0;
  logic                       cfg_vld = 1'b0;
  logic                       cfg_rdy, cfg_drop;
  logic [CH_NUM-1:0]          run, mode_vld, fword_vld, pword_vld, duty_vld;
  logic [CH_NUM*3-1:0]        mode;
  logic [CH_NUM*FWORD_W-1:0]  fword;
  logic [CH_NUM*PWORD_W-1:0]  pword;
  logic [CH_NUM*10-1:0]       duty;
  logic [CH_NUM*DATA_W-1:0]   dds_data = '0;
  logic                       dds_vld = 1'b0;
  logic [CH_NUM*DATA_W-1:0]   pay_data;
  logic                       pay_vld;

  int total = 0;
  int bad = 0;

  dds_ctrl_mc #(.CH_NUM(CH_NUM)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cfg_ch(cfg_ch), .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data), .i_cfg_vld(cfg_vld),
    .o_cfg_rdy(cfg_rdy), .o_cfg_drop(cfg_drop),
    .o_run(run), .o_mode(mode), .o_mode_vld(mode_vld),
    .o_fword(fword), .o_fword_vld(fword_vld),
    .o_pword(pword), .o_pword_vld(pword_vld),
    .o_duty(duty), .o_duty_vld(duty_vld),
    .i_dds_data(dds_data), .i_dds_data_vld(dds_vld),
    .o_pay_dds_data(pay_data), .o_pay_vld(pay_vld)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [CH_W-1:0] ch, input logic [2:0] sel, input logic [15:0] data);
    cfg_ch = ch; cfg_sel = sel; cfg_data = data; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (cfg_rdy !== 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic run_sample(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                            input logic [DATA_W-1:0] d2, output logic [CH_NUM*DATA_W-1:0] got,
                            output logic v2, output logic v3);
    dds_data = {d2, d1, d0}; dds_vld = 1'b1;
    tick();
    dds_vld = 1'b0; dds_data = '0;
    tick();
    v2 = pay_vld;
    tick();
    v3 = pay_vld;
    got = pay_data;
  endtask

  task automatic test_reset();
    total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%0b exp=1", cfg_rdy); end
    total++; if (run !== 3'b111) begin bad++; $display("FAIL reset_run got=%b exp=111", run); end
    total++; if (fword !== {27'd64, 27'd64, 27'd64}) begin bad++; $display("FAIL reset_fword got=%h", fword); end
    total++; if (pword !== '0 || mode !== '0) begin bad++; $display("FAIL reset_pword_mode pword=%h mode=%h exp=0", pword, mode); end
    total++; if (duty !== {10'd1, 10'd1, 10'd1}) begin bad++; $display("FAIL reset_duty got=%h", duty); end
    total++; if ({mode_vld, fword_vld, pword_vld, duty_vld, cfg_drop, pay_vld} !== '0 || pay_data !== '0) begin
      bad++; $display("FAIL reset_pulses got=%b data=%h exp=0", {mode_vld, fword_vld, pword_vld, duty_vld, cfg_drop, pay_vld}, pay_data);
    end
  endtask

  task automatic test_passthrough();
    logic [CH_NUM*DATA_W-1:0] got;
    logic v2, v3;
    run_sample(14'd1000, 14'd1000, 14'd1000, got, v2, v3);
    total++; if (v2 !== 1'b0) begin bad++; $display("FAIL pass_early_vld got=%0b exp=0", v2); end
    total++; if (v3 !== 1'b1) begin bad++; $display("FAIL pass_vld got=%0b exp=1", v3); end
    total++; if (got !== {14'd1000, 14'd1000, 14'd1000}) begin bad++; $display("FAIL pass_data got=%h", got); end
  endtask

  task automatic test_frq();
    int n;
    cfg_write(2'd1, 3'd2, 16'd50000);
    total++; if (cfg_rdy !== 1'b0) begin bad++; $display("FAIL frq_busy got=%0b exp=0", cfg_rdy); end
    wait_idle(n);
    total++; if (n !== NUM_W + 2) begin bad++; $display("FAIL frq_busy_len got=%0d exp=%0d", n, NUM_W + 2); end
    total++; if (fword_vld !== 3'b010) begin bad++; $display("FAIL frq_vld got=%b exp=010", fword_vld); end
    total++; if (fword[FWORD_W +: FWORD_W] !== 27'd6710886) begin bad++; $display("FAIL frq_ch1 got=%0d exp=6710886", fword[FWORD_W +: FWORD_W]); end
    total++; if (fword[0 +: FWORD_W] !== 27'd64 || fword[2*FWORD_W +: FWORD_W] !== 27'd64) begin
      bad++; $display("FAIL frq_others ch0=%0d ch2=%0d exp=64", fword[0 +: FWORD_W], fword[2*FWORD_W +: FWORD_W]);
    end
    tick();
    total++; if (fword_vld !== 3'b000) begin bad++; $display("FAIL frq_vld_len got=%b exp=000", fword_vld); end
  endtask

  task automatic test_phase_drop();
    int n;
    cfg_write(2'd0, 3'd6, 16'd900);
    cfg_ch = 2'd0; cfg_sel = 3'd6; cfg_data = 16'd4000; cfg_vld = 1'b1;
    tick();
    cfg_vld = 1'b0;
    total++; if (cfg_drop !== 1'b1) begin bad++; $display("FAIL busy_drop got=%0b exp=1", cfg_drop); end
    wait_idle(n);
    total++; if (n >= 200) begin bad++; $display("FAIL phase_timeout got=%0d exp<200", n); end
    total++; if (pword_vld !== 3'b001) begin bad++; $display("FAIL phase_vld got=%b exp=001", pword_vld); end
    total++; if (pword[7:0] !== 8'd64) begin bad++; $display("FAIL phase_900 got=%0d exp=64", pword[7:0]); end
    cfg_write(2'd0, 3'd6, 16'd4000);
    wait_idle(n);
    total++; if (pword !== {8'd0, 8'd0, 8'd255}) begin bad++; $display("FAIL phase_clamp got=%h exp=0000ff", pword); end
  endtask

  task automatic test_direct();
    cfg_write(2'd2, 3'd1, 16'd5);
    total++; if (mode_vld !== 3'b100 || mode[8:6] !== 3'd5) begin bad++; $display("FAIL mode_write vld=%b mode=%0d exp=100/5", mode_vld, mode[8:6]); end
    total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL direct_rdy got=%0b exp=1", cfg_rdy); end
    tick();
    total++; if (mode_vld !== 3'b000 || mode !== {3'd5, 3'd0, 3'd0}) begin bad++; $display("FAIL mode_hold vld=%b mode=%h", mode_vld, mode); end
    cfg_write(2'd1, 3'd7, 16'd500);
    total++; if (duty_vld !== 3'b010 || duty[19:10] !== 10'd500) begin bad++; $display("FAIL duty_write vld=%b duty=%0d exp=010/500", duty_vld, duty[19:10]); end
  endtask

  task automatic test_gain();
    int n;
    logic [CH_NUM*DATA_W-1:0] got;
    logic v2, v3;
    cfg_write(2'd0, 3'd3, 16'd1500);
    wait_idle(n);
    run_sample(14'd16000, 14'd16000, 14'd3, got, v2, v3);
    total++; if (got !== {14'd3, 14'd16000, 14'd8000}) begin bad++; $display("FAIL amp_half got=%h exp ch0=8000 ch1=16000 ch2=3", got); end
    cfg_write(2'd0, 3'd3, 16'd5000);
    wait_idle(n);
    run_sample(14'd100, 14'd0, 14'd0, got, v2, v3);
    total++; if (got[13:0] !== 14'd136) begin bad++; $display("FAIL amp_clamp got=%0d exp=136", got[13:0]); end
    cfg_write(2'd0, 3'd4, 16'd6000);
    wait_idle(n);
    run_sample(14'd16000, 14'd0, 14'd0, got, v2, v3);
    total++; if (got[13:0] !== 14'd16000 || v3 !== 1'b1) begin bad++; $display("FAIL p2p_unity got=%0d vld=%0b exp=16000/1", got[13:0], v3); end
  endtask

  task automatic test_offset();
    int n;
    logic [CH_NUM*DATA_W-1:0] got;
    logic v2, v3;
    cfg_write(2'd0, 3'd5, 16'd3000);
    wait_idle(n);
    run_sample(14'd10000, 14'd10000, 14'd0, got, v2, v3);
    total++; if (got[27:0] !== {14'd10000, 14'd16383}) begin bad++; $display("FAIL ofs_sat got=%h exp ch0=16383 ch1=10000", got[27:0]); end
    run_sample(14'd0, 14'd0, 14'd0, got, v2, v3);
    total++; if (got[13:0] !== 14'd8192) begin bad++; $display("FAIL ofs_zero got=%0d exp=8192", got[13:0]); end
    run_sample(14'd8191, 14'd0, 14'd0, got, v2, v3);
    total++; if (got[13:0] !== 14'd16383) begin bad++; $display("FAIL ofs_edge got=%0d exp=16383", got[13:0]); end
    cfg_write(2'd0, 3'd5, 16'd9000);
    wait_idle(n);
    run_sample(14'd0, 14'd0, 14'd0, got, v2, v3);
    total++; if (got[13:0] !== 14'd16383) begin bad++; $display("FAIL ofs_clamp got=%0d exp=16383", got[13:0]); end
    cfg_write(2'd3, 3'd0, 16'd0);
    total++; if (cfg_drop !== 1'b1) begin bad++; $display("FAIL badch_drop got=%0b exp=1", cfg_drop); end
    total++; if (run !== 3'b111 || cfg_rdy !== 1'b1) begin bad++; $display("FAIL badch_state run=%b rdy=%0b exp=111/1", run, cfg_rdy); end
    tick();
    total++; if (cfg_drop !== 1'b0) begin bad++; $display("FAIL drop_len got=%0b exp=0", cfg_drop); end
  endtask

  task automatic test_reset_mid_div();
    int pulses = 0;
    cfg_write(2'd0, 3'd2, 16'd1234);
    repeat (10) tick();
    total++; if (cfg_rdy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b exp=0", cfg_rdy); end
    rst_n = 1'b0;
    #2;
    total++; if (cfg_rdy !== 1'b1) begin bad++; $display("FAIL async_rdy got=%0b exp=1", cfg_rdy); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (fword_vld !== 3'b000) pulses++;
      tick();
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL abort_vld got=%0d exp=0", pulses); end
    total++; if (fword !== {27'd64, 27'd64, 27'd64} || cfg_rdy !== 1'b1) begin bad++; $display("FAIL abort_state fword=%h rdy=%0b", fword, cfg_rdy); end
    cfg_write(2'd0, 3'd0, 16'd0);
    total++; if (run !== 3'b110) begin bad++; $display("FAIL run_off got=%b exp=110", run); end
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    $display("[TB] starting directed tests");
    test_reset();
    test_passthrough();
    test_frq();
    test_phase_drop();
    test_direct();
    test_gain();
    test_offset();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end
endmodule
